// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; waits for data SRAM data_ok, extends load data, feeds WB and decode bypass.
// Optional MS_FWD_EN drives ms_to_ds_fwd_bus; when undefined the bypass bus is tied to zero.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 75,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_FWD_BUS_WD   = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_FWD_BUS_WD-1:0]   ms_to_ds_fwd_bus
);
  logic                       ms_valid;
  logic                       buf_valid;
  logic [31:0]                buf_rdata;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
  logic                       mem_req;
  logic                       res_from_mem;
  logic [2:0]                 mem_op;
  logic                       gr_we;
  logic [4:0]                 dest;
  logic [31:0]                alu_result;
  logic [31:0]                pc;
  logic                       ms_ready_go;
  logic                       accept;
  logic                       leave;
  logic [31:0]                word;
  logic [31:0]                shifted;
  logic [7:0]                 byte_sel;
  logic [15:0]                half_sel;
  logic [31:0]                load_result;
  logic [31:0]                final_result;
  assign {mem_req, res_from_mem, mem_op, gr_we, dest, alu_result, pc} = es_to_ms_bus_r;
  assign ms_ready_go    = ~mem_req | buf_valid | data_sram_data_ok;
  assign ms_to_ws_valid = ms_valid & ms_ready_go;
  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
  assign accept         = ms_valid & mem_req & ~buf_valid & data_sram_data_ok;
  assign leave          = ms_to_ws_valid & ws_allowin;
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid  <= 1'b0;
      buf_valid <= 1'b0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (leave) buf_valid <= 1'b0;
      else if (accept & ~ws_allowin) buf_valid <= 1'b1;
    end
  end
  // payload registers carry no reset; they are qualified by ms_valid / buf_valid
  always_ff @(posedge clk) begin
    if (es_to_ms_valid & ms_allowin) es_to_ms_bus_r <= es_to_ms_bus;
    if (accept & ~ws_allowin) buf_rdata <= data_sram_rdata;
  end
  always_comb begin
    word     = buf_valid ? buf_rdata : data_sram_rdata;
    shifted  = word >> {alu_result[1:0], 3'b000};
    byte_sel = shifted[7:0];
    half_sel = alu_result[1] ? word[31:16] : word[15:0];
    load_result = mem_op == 3'b001 ? {{24{byte_sel[7]}}, byte_sel} :
                  mem_op == 3'b101 ? {24'b0, byte_sel} :
                  mem_op == 3'b010 ? {{16{half_sel[15]}}, half_sel} :
                  mem_op == 3'b110 ? {16'b0, half_sel} : word;
    final_result = res_from_mem ? load_result : alu_result;
  end
  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
`ifdef MS_FWD_EN
  assign ms_to_ds_fwd_bus = {ms_valid & res_from_mem & ~ms_ready_go, ms_valid & gr_we, dest, final_result};
`else
  assign ms_to_ds_fwd_bus = '0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage (handshake, load extension, response buffer, reset).
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [74:0] es_to_ms_bus;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [38:0] ms_to_ds_fwd_bus;
  int checks = 0;
  int errors = 0;
  mem_stage dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ms_to_ds_fwd_bus(ms_to_ds_fwd_bus)
  );
  always #5 clk = ~clk;
  function automatic logic [74:0] mk(input logic mr, input logic rm, input logic [2:0] op,
                                     input logic we, input logic [4:0] d, input logic [31:0] a,
                                     input logic [31:0] p);
    return {mr, rm, op, we, d, a, p};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic enter(input logic [74:0] b);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = b;
    tick();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %b want 1", ms_allowin); end
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ms_to_ws_valid); end
    checks++; if (ms_to_ds_fwd_bus[38:37] !== 2'b00) begin errors++; $display("FAIL reset_fwd got %b want 00", ms_to_ds_fwd_bus[38:37]); end
    tick();
    reset = 1'b0;
  endtask
  task automatic test_alu;
    enter(mk(1'b0, 1'b0, 3'b000, 1'b1, 5'd5, 32'h0000_1234, 32'h1c00_0000));
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL alu_valid got %b want 1", ms_to_ws_valid); end
    checks++; if (ms_to_ws_bus !== {1'b1, 5'd5, 32'h0000_1234, 32'h1c00_0000}) begin errors++; $display("FAIL alu_bus got %h want %h", ms_to_ws_bus, {1'b1, 5'd5, 32'h0000_1234, 32'h1c00_0000}); end
`ifdef MS_FWD_EN
    checks++; if (ms_to_ds_fwd_bus !== {1'b0, 1'b1, 5'd5, 32'h0000_1234}) begin errors++; $display("FAIL alu_fwd got %h want %h", ms_to_ds_fwd_bus, {1'b0, 1'b1, 5'd5, 32'h0000_1234}); end
`else
    checks++; if (ms_to_ds_fwd_bus !== 39'd0) begin errors++; $display("FAIL alu_fwd_off got %h want 0", ms_to_ds_fwd_bus); end
`endif
    tick();
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL alu_drain got %b want 0", ms_to_ws_valid); end
  endtask
  task automatic test_ldb_wait;
    enter(mk(1'b1, 1'b1, 3'b001, 1'b1, 5'd7, 32'h1c00_1001, 32'h1c00_0010));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0) begin errors++; $display("FAIL ldb_wait%0d got valid=%b allowin=%b want 0 0", i, ms_to_ws_valid, ms_allowin); end
`ifdef MS_FWD_EN
      checks++; if (ms_to_ds_fwd_bus[38] !== 1'b1) begin errors++; $display("FAIL ldb_blocked%0d got %b want 1", i, ms_to_ds_fwd_bus[38]); end
`endif
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0000_80FF;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL ldb_done got %b want 1", ms_to_ws_valid); end
    checks++; if (ms_to_ws_bus[63:32] !== 32'hFFFF_FF80) begin errors++; $display("FAIL ldb_result got %h want ffffff80", ms_to_ws_bus[63:32]); end
`ifdef MS_FWD_EN
    checks++; if (ms_to_ds_fwd_bus[38] !== 1'b0) begin errors++; $display("FAIL ldb_unblocked got %b want 0", ms_to_ds_fwd_bus[38]); end
`endif
    tick();
    data_sram_data_ok = 1'b0;
  endtask
  task automatic load_case(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rd, input logic [31:0] exp);
    enter(mk(1'b1, 1'b1, op, 1'b1, 5'd9, addr, 32'h1c00_0100));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = rd;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== exp) begin errors++; $display("FAIL load op=%b addr=%h got valid=%b %h want 1 %h", op, addr, ms_to_ws_valid, ms_to_ws_bus[63:32], exp); end
    tick();
    data_sram_data_ok = 1'b0;
  endtask
  task automatic test_load_ext;
    load_case(3'b110, 32'h1c00_2002, 32'hBEEF_1234, 32'h0000_BEEF);
    load_case(3'b010, 32'h1c00_2002, 32'hBEEF_1234, 32'hFFFF_BEEF);
    load_case(3'b000, 32'h1c00_2000, 32'hBEEF_1234, 32'hBEEF_1234);
    load_case(3'b101, 32'h1c00_2003, 32'hBEEF_1234, 32'h0000_00BE);
    load_case(3'b001, 32'h1c00_2000, 32'hBEEF_1234, 32'h0000_0034);
    load_case(3'b010, 32'h1c00_2000, 32'h1234_8001, 32'hFFFF_8001);
    load_case(3'b111, 32'h1c00_2001, 32'h1234_5678, 32'h1234_5678);
  endtask
  task automatic test_buffer;
    ws_allowin = 1'b0;
    enter(mk(1'b1, 1'b1, 3'b000, 1'b1, 5'd3, 32'h1c00_3000, 32'h1c00_0200));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin errors++; $display("FAIL buf_ok got valid=%b allowin=%b want 1 0", ms_to_ws_valid, ms_allowin); end
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (ms_to_ws_bus[63:32] !== 32'hCAFE_F00D) begin errors++; $display("FAIL buf_hold got %h want cafef00d", ms_to_ws_bus[63:32]); end
    tick();
    ws_allowin = 1'b1;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hCAFE_F00D || ms_allowin !== 1'b1) begin errors++; $display("FAIL buf_leave got valid=%b %h allowin=%b want 1 cafef00d 1", ms_to_ws_valid, ms_to_ws_bus[63:32], ms_allowin); end
    tick();
    enter(mk(1'b1, 1'b1, 3'b000, 1'b1, 5'd3, 32'h1c00_3004, 32'h1c00_0204));
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL buf_cleared got %b want 0", ms_to_ws_valid); end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1111_2222;
    #1;
    checks++; if (ms_to_ws_bus[63:32] !== 32'h1111_2222) begin errors++; $display("FAIL buf_fresh got %h want 11112222", ms_to_ws_bus[63:32]); end
    tick();
    data_sram_data_ok = 1'b0;
  endtask
  task automatic test_store;
    enter(mk(1'b1, 1'b0, 3'b000, 1'b0, 5'd0, 32'h1c00_4000, 32'h1c00_0300));
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0) begin errors++; $display("FAIL st_wait got valid=%b allowin=%b want 0 0", ms_to_ws_valid, ms_allowin); end
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h5555_5555;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== {1'b0, 5'd0, 32'h1c00_4000, 32'h1c00_0300}) begin errors++; $display("FAIL st_done got valid=%b %h want 1 %h", ms_to_ws_valid, ms_to_ws_bus, {1'b0, 5'd0, 32'h1c00_4000, 32'h1c00_0300}); end
    tick();
    data_sram_data_ok = 1'b0;
  endtask
  task automatic test_back_to_back;
    enter(mk(1'b0, 1'b0, 3'b000, 1'b1, 5'd1, 32'h0000_00AA, 32'h1c00_0400));
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b0, 1'b0, 3'b000, 1'b1, 5'd2, 32'h0000_00BB, 32'h1c00_0404);
    @(negedge clk);
    checks++; if (ms_allowin !== 1'b1 || ms_to_ws_bus !== {1'b1, 5'd1, 32'h0000_00AA, 32'h1c00_0400}) begin errors++; $display("FAIL b2b_first got allowin=%b %h", ms_allowin, ms_to_ws_bus); end
    tick();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== {1'b1, 5'd2, 32'h0000_00BB, 32'h1c00_0404}) begin errors++; $display("FAIL b2b_second got valid=%b %h", ms_to_ws_valid, ms_to_ws_bus); end
    tick();
  endtask
  task automatic test_reset_wait;
    enter(mk(1'b1, 1'b1, 3'b000, 1'b1, 5'd4, 32'h1c00_5000, 32'h1c00_0500));
    @(negedge clk);
`ifdef MS_FWD_EN
    checks++; if (ms_to_ds_fwd_bus[38] !== 1'b1) begin errors++; $display("FAIL rw_blocked got %b want 1", ms_to_ds_fwd_bus[38]); end
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin errors++; $display("FAIL rw_drop got valid=%b allowin=%b want 0 1", ms_to_ws_valid, ms_allowin); end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h7777_7777;
    #1;
    checks++; if (ms_to_ws_valid !== 1'b0 || ms_to_ds_fwd_bus[38:37] !== 2'b00) begin errors++; $display("FAIL rw_late got valid=%b fwd=%b want 0 00", ms_to_ws_valid, ms_to_ds_fwd_bus[38:37]); end
    tick();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin errors++; $display("FAIL rw_after got valid=%b allowin=%b want 0 1", ms_to_ws_valid, ms_allowin); end
  endtask
  initial begin
    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    test_reset();
    test_alu();
    test_ldb_wait();
    test_load_ext();
    test_buffer();
    test_store();
    test_back_to_back();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
